rgb_pwm_fader: RTL

- Downstream stage of the RGB blinker.
- Consumes the blinker's on/off levels r/g/b as per-channel targets.
- Ramps each channel's brightness up or down in steps on every fade strobe, then drives the LED pins with glitch-free PWM.
- Sits between the blinker and the top-level LED pads, in the same clock domain.

---
 rtl/rgb_pwm_fader.sv | 105 ++++++++++
 1 files changed

// File: rtl/rgb_pwm_fader.sv
// Three-channel brightness fader with glitch-free PWM output for the RGB blinker LEDs.
// Define RGB_PWM_FADER_GAMMA_EN to apply a square-law perceptual curve at the compare latch.
module rgb_pwm_fader #(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 16,
    parameter int MAX_LEVEL = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fade_tick,
    input  logic                r_in,
    input  logic                g_in,
    input  logic                b_in,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic [PWM_BITS-1:0] level_r,
    output logic [PWM_BITS-1:0] level_g,
    output logic [PWM_BITS-1:0] level_b,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] MAX_LVL  = MAX_LEVEL[PWM_BITS-1:0];
    localparam logic [PWM_BITS-1:0] STEP     = FADE_STEP[PWM_BITS-1:0];
    localparam logic [PWM_BITS-1:0] CNT_ONE  = 1;
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level      [3];
    logic [PWM_BITS-1:0] next_level [3];
    logic [PWM_BITS-1:0] cmp        [3];
    logic [PWM_BITS-1:0] cmp_next   [3];
    logic [PWM_BITS:0]   sum        [3];
    logic [2:0]          target;
    logic [2:0]          fading;
    logic [2:0]          led;

    assign target = {b_in, g_in, r_in};

    // NOTE: every combinational output gets a default before the branches so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            // Sum is one bit wider than the level so the clamp sees overflow instead of a wrapped value.
            sum[i]        = {1'b0, level[i]} + {1'b0, STEP};
            next_level[i] = level[i];
            if (fade_tick) begin
                if (target[i] && (level[i] < MAX_LVL)) begin
                    next_level[i] = (sum[i] > {1'b0, MAX_LVL}) ? MAX_LVL : sum[i][PWM_BITS-1:0];
                end else if (!target[i] && (level[i] != '0)) begin
                    next_level[i] = (level[i] > STEP) ? (level[i] - STEP) : '0;
                end
            end
            fading[i] = target[i] ? (level[i] < MAX_LVL) : (level[i] != '0);
        end
    end

`ifdef RGB_PWM_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] prod [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            prod[i]     = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
            cmp_next[i] = prod[i][2*PWM_BITS-1:PWM_BITS];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cmp_next[i] = level[i];
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            led     <= '0;
            busy    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                level[i] <= '0;
                cmp[i]   <= '0;
            end
        end else begin
            pwm_cnt <= pwm_cnt + CNT_ONE;
            busy    <= |fading;
            for (int i = 0; i < 3; i++) begin
                level[i] <= next_level[i];
                // Duty only reloads at the wrap, so a period is never cut short or stretched.
                if (pwm_cnt == CNT_LAST) begin
                    cmp[i] <= cmp_next[i];
                end
                led[i] <= (pwm_cnt < cmp[i]);
            end
        end
    end

    assign level_r = level[0];
    assign level_g = level[1];
    assign level_b = level[2];
    assign led_r   = led[0];
    assign led_g   = led[1];
    assign led_b   = led[2];

endmodule
